// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared error codes and FSM state types for the UART command framer
package uart_cmd_pkg;
  typedef enum logic [1:0] {ERR_NONE, ERR_TIMEOUT, ERR_CHKSUM, ERR_OVERRUN} err_t;
  typedef enum logic {RX_IDLE, RX_COLLECT} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_LOAD, TX_WAIT} tx_state_t;
endpackage

// File: rtl/UART.sv
// UART: byte-level 8N1 receiver/transmitter, BAUD_DIV clocks per bit
module UART #(
  parameter int BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  output logic       TX,
  output logic [7:0] rx_data,
  output logic       rdy,
  input  logic       clr_rdy,
  input  logic [7:0] tx_data,
  input  logic       trmt,
  output logic       tx_done
);
  localparam int CW = $clog2(BAUD_DIV);
  logic          rx_s1_q, rx_s2_q, rx_busy_q, rx_busy_d, rdy_q, rdy_d;
  logic          tx_busy_q, tx_busy_d, tx_done_q, tx_done_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
  logic [3:0]    rx_bits_q, rx_bits_d, tx_bits_q, tx_bits_d;
  logic [8:0]    rx_sh_q, rx_sh_d;
  logic [9:0]    tx_sh_q, tx_sh_d;
  // Receiver samples mid-bit: half a period after the start edge, then every period
  always_comb begin
    rx_busy_d = rx_busy_q;
    rx_cnt_d  = rx_cnt_q;
    rx_bits_d = rx_bits_q;
    rx_sh_d   = rx_sh_q;
    rdy_d     = clr_rdy ? 1'b0 : rdy_q;
    if (!rx_busy_q) begin
      if (!rx_s2_q) begin
        rx_busy_d = 1'b1;
        rx_cnt_d  = CW'(BAUD_DIV / 2);
        rx_bits_d = '0;
      end
    end else if (rx_cnt_q == '0) begin
      rx_sh_d   = {rx_s2_q, rx_sh_q[8:1]};
      rx_bits_d = rx_bits_q + 4'd1;
      rx_cnt_d  = CW'(BAUD_DIV - 1);
      if (rx_bits_q == 4'd9) begin
        rx_busy_d = 1'b0;
        rdy_d     = 1'b1;
      end
    end else begin
      rx_cnt_d = rx_cnt_q - CW'(1);
    end
  end
  always_comb begin
    tx_busy_d = tx_busy_q;
    tx_cnt_d  = tx_cnt_q;
    tx_bits_d = tx_bits_q;
    tx_sh_d   = tx_sh_q;
    tx_done_d = 1'b0;
    if (trmt) begin
      tx_sh_d   = {1'b1, tx_data, 1'b0};
      tx_busy_d = 1'b1;
      tx_cnt_d  = CW'(BAUD_DIV - 1);
      tx_bits_d = '0;
    end else if (tx_busy_q) begin
      if (tx_cnt_q == '0) begin
        tx_sh_d   = {1'b1, tx_sh_q[9:1]};
        tx_cnt_d  = CW'(BAUD_DIV - 1);
        tx_bits_d = tx_bits_q + 4'd1;
        if (tx_bits_q == 4'd9) begin
          tx_busy_d = 1'b0;
          tx_done_d = 1'b1;
        end
      end else begin
        tx_cnt_d = tx_cnt_q - CW'(1);
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_busy_q <= 1'b0;
      rx_cnt_q  <= '0;
      rx_bits_q <= '0;
      rx_sh_q   <= '0;
      rdy_q     <= 1'b0;
      tx_busy_q <= 1'b0;
      tx_cnt_q  <= '0;
      tx_bits_q <= '0;
      tx_sh_q   <= '1;
      tx_done_q <= 1'b0;
    end else begin
      rx_s1_q   <= RX;
      rx_s2_q   <= rx_s1_q;
      rx_busy_q <= rx_busy_d;
      rx_cnt_q  <= rx_cnt_d;
      rx_bits_q <= rx_bits_d;
      rx_sh_q   <= rx_sh_d;
      rdy_q     <= rdy_d;
      tx_busy_q <= tx_busy_d;
      tx_cnt_q  <= tx_cnt_d;
      tx_bits_q <= tx_bits_d;
      tx_sh_q   <= tx_sh_d;
      tx_done_q <= tx_done_d;
    end
  end
  assign TX      = tx_sh_q[0];
  assign rx_data = rx_sh_q[7:0];
  assign rdy     = rdy_q;
  assign tx_done = tx_done_q;
endmodule

// File: rtl/uart_cmd_frm.sv
// uart_cmd_frm: frames multi-byte commands from the UART (timeout, checksum,
// overrun detection) and serialises multi-byte responses back out.
module uart_cmd_frm
  import uart_cmd_pkg::*;
#(
  parameter int CMD_BYTES = 3,
  parameter int RSP_BYTES = 1,
  parameter int CHKSUM_EN = 0,
  parameter int TO_CYCLES = 50000,
  parameter int BAUD_DIV  = 434
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   RX,
  output logic                   TX,
  input  logic                   clr_cmd_rdy,
  output logic [8*CMD_BYTES-1:0] cmd,
  output logic                   cmd_rdy,
  output logic                   frm_err,
  output logic [1:0]             err_code,
  input  logic [8*RSP_BYTES-1:0] rsp_data,
  input  logic                   send_rsp,
  output logic                   rsp_busy,
  output logic                   rsp_done
);
  localparam int FRM = CMD_BYTES + CHKSUM_EN;
  localparam int IW  = $clog2(CMD_BYTES + 2);
  localparam int GW  = $clog2(TO_CYCLES + 1);
  localparam int CW  = $clog2(RSP_BYTES + 1);
  localparam int CB  = 8 * CMD_BYTES;
  localparam int RB  = 8 * RSP_BYTES;
  rx_state_t rx_state_q, rx_state_d;
  tx_state_t tx_state_q, tx_state_d;
  err_t      err_q, err_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]    sum_q, sum_d, sum_nx, rx_data, tx_data;
  logic [CB-1:0] shadow_q, shadow_d, shadow_w, cmd_q, cmd_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [RB-1:0] tx_sh_q, tx_sh_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic cmd_rdy_q, cmd_rdy_d, frm_err_q, frm_err_d, rsp_done_q, rsp_done_d;
  logic rdy, clr_rdy, trmt, tx_done;
  UART #(.BAUD_DIV(BAUD_DIV)) u_uart (
    .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX),
    .rx_data(rx_data), .rdy(rdy), .clr_rdy(clr_rdy),
    .tx_data(tx_data), .trmt(trmt), .tx_done(tx_done)
  );
  assign clr_rdy = rdy;
  assign sum_nx  = sum_q + rx_data;
  // The timeout compare sits two below TO_CYCLES so frm_err lands TO_CYCLES after rdy
  always_comb begin
    rx_state_d = rx_state_q;
    idx_d      = idx_q;
    sum_d      = sum_q;
    shadow_d   = shadow_q;
    gap_d      = gap_q;
    cmd_d      = cmd_q;
    cmd_rdy_d  = clr_cmd_rdy ? 1'b0 : cmd_rdy_q;
    err_d      = clr_cmd_rdy ? ERR_NONE : err_q;
    frm_err_d  = 1'b0;
    shadow_w   = shadow_q;
    for (int k = 0; k < CMD_BYTES; k++)
      if (idx_q == IW'(k)) shadow_w[8*(CMD_BYTES-k)-1 -: 8] = rx_data;
    if (rdy) begin
      gap_d = '0;
      if (idx_q == IW'(FRM - 1)) begin
        rx_state_d = RX_IDLE;
        idx_d      = '0;
        sum_d      = '0;
        shadow_d   = '0;
        if (CHKSUM_EN != 0 && sum_nx != 8'h00) begin
          frm_err_d = 1'b1;
          err_d     = ERR_CHKSUM;
        end else if (cmd_rdy_q && !clr_cmd_rdy) begin
          frm_err_d = 1'b1;
          err_d     = ERR_OVERRUN;
        end else begin
          cmd_d     = shadow_w;
          cmd_rdy_d = 1'b1;
        end
      end else begin
        rx_state_d = RX_COLLECT;
        idx_d      = idx_q + IW'(1);
        sum_d      = sum_nx;
        shadow_d   = shadow_w;
      end
    end else if (rx_state_q == RX_COLLECT) begin
      if (gap_q == GW'(TO_CYCLES - 2)) begin
        rx_state_d = RX_IDLE;
        idx_d      = '0;
        sum_d      = '0;
        shadow_d   = '0;
        gap_d      = '0;
        frm_err_d  = 1'b1;
        err_d      = ERR_TIMEOUT;
      end else begin
        gap_d = gap_q + GW'(1);
      end
    end
  end
  always_comb begin
    tx_state_d = tx_state_q;
    tx_sh_d    = tx_sh_q;
    tx_cnt_d   = tx_cnt_q;
    rsp_done_d = 1'b0;
    trmt       = 1'b0;
    if (tx_state_q == TX_IDLE) begin
      if (send_rsp) begin
        tx_sh_d    = rsp_data;
        tx_cnt_d   = CW'(RSP_BYTES);
        tx_state_d = TX_LOAD;
      end
    end else if (tx_state_q == TX_LOAD) begin
      trmt       = 1'b1;
      tx_state_d = TX_WAIT;
    end else if (tx_done) begin
      tx_sh_d    = tx_sh_q << 8;
      tx_cnt_d   = tx_cnt_q - CW'(1);
      rsp_done_d = tx_cnt_q == CW'(1);
      tx_state_d = tx_cnt_q == CW'(1) ? TX_IDLE : TX_LOAD;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= RX_IDLE;
      idx_q      <= '0;
      sum_q      <= '0;
      shadow_q   <= '0;
      gap_q      <= '0;
      cmd_q      <= '0;
      cmd_rdy_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      err_q      <= ERR_NONE;
      tx_state_q <= TX_IDLE;
      tx_sh_q    <= '0;
      tx_cnt_q   <= '0;
      rsp_done_q <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      idx_q      <= idx_d;
      sum_q      <= sum_d;
      shadow_q   <= shadow_d;
      gap_q      <= gap_d;
      cmd_q      <= cmd_d;
      cmd_rdy_q  <= cmd_rdy_d;
      frm_err_q  <= frm_err_d;
      err_q      <= err_d;
      tx_state_q <= tx_state_d;
      tx_sh_q    <= tx_sh_d;
      tx_cnt_q   <= tx_cnt_d;
      rsp_done_q <= rsp_done_d;
    end
  end
  assign tx_data  = tx_sh_q[RB-1 -: 8];
  assign cmd      = cmd_q;
  assign cmd_rdy  = cmd_rdy_q;
  assign frm_err  = frm_err_q;
  assign err_code = err_q;
  assign rsp_busy = tx_state_q != TX_IDLE;
  assign rsp_done = rsp_done_q;
endmodule

// File: tb/tb_uart_cmd_frm.sv
// tb_uart_cmd_frm: scoreboard bench for the command framer and response path
module tb_uart_cmd_frm;
  import uart_cmd_pkg::*;
  typedef struct { logic is_err; logic [31:0] val; int lat; } exp_t;
  logic clk = 0, rst_n = 0;
  logic rx0 = 1, rx1 = 1, clr0 = 0, clr1 = 0, send0 = 0;
  logic tx0, tx1, cmd_rdy0, cmd_rdy1, frm_err0, frm_err1;
  logic rsp_busy0, rsp_busy1, rsp_done0, rsp_done1;
  logic [1:0]  err_code0, err_code1;
  logic [23:0] cmd0;
  logic [15:0] cmd1, rsp_data0 = 16'hC35A;
  logic [7:0]  b;
  int cyc = 0, rdy0 = -100, rdy1 = -100, txd0 = -100, ndone = 0;
  int n_chk = 0, n_err = 0;
  logic prev0 = 0, prev1 = 0;
  exp_t q0[$], q1[$], e0, e1;
  logic [7:0] txq[$];
  uart_cmd_frm #(.CMD_BYTES(3), .RSP_BYTES(2), .CHKSUM_EN(0), .TO_CYCLES(2000), .BAUD_DIV(16)) d0 (
    .clk(clk), .rst_n(rst_n), .RX(rx0), .TX(tx0), .clr_cmd_rdy(clr0), .cmd(cmd0),
    .cmd_rdy(cmd_rdy0), .frm_err(frm_err0), .err_code(err_code0), .rsp_data(rsp_data0),
    .send_rsp(send0), .rsp_busy(rsp_busy0), .rsp_done(rsp_done0));
  uart_cmd_frm #(.CMD_BYTES(2), .RSP_BYTES(1), .CHKSUM_EN(1), .TO_CYCLES(2000), .BAUD_DIV(16)) d1 (
    .clk(clk), .rst_n(rst_n), .RX(rx1), .TX(tx1), .clr_cmd_rdy(clr1), .cmd(cmd1),
    .cmd_rdy(cmd_rdy1), .frm_err(frm_err1), .err_code(err_code1), .rsp_data(8'h00),
    .send_rsp(1'b0), .rsp_busy(rsp_busy1), .rsp_done(rsp_done1));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic send_byte(input bit which, input logic [7:0] v);
    logic [9:0] f = {1'b1, v, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (which) rx1 = f[i]; else rx0 = f[i];
      repeat (16) @(negedge clk);
    end
  endtask
  task automatic send_frm(input bit which, input int n, input logic [31:0] f);
    for (int i = 0; i < n; i++) send_byte(which, f[8*(n-1-i) +: 8]);
    repeat (4) @(negedge clk);
  endtask
  // Events are timestamped against the internal rdy/tx_done strobes to verify latency
  always @(negedge clk) begin
    if (!rst_n) begin
      prev0 = 0;
      prev1 = 0;
    end else begin
      if (frm_err0 || (cmd_rdy0 && !prev0)) begin
        if (q0.size() == 0) check("d0_unexpected_event", 32'(q0.size()), 1);
        else begin
          e0 = q0.pop_front();
          check("d0_kind", 32'(frm_err0), 32'(e0.is_err));
          check("d0_val", e0.is_err ? 32'(err_code0) : 32'(cmd0), e0.val);
          check("d0_lat", cyc - rdy0, e0.lat);
        end
      end
      if (frm_err1 || (cmd_rdy1 && !prev1)) begin
        if (q1.size() == 0) check("d1_unexpected_event", 32'(q1.size()), 1);
        else begin
          e1 = q1.pop_front();
          check("d1_kind", 32'(frm_err1), 32'(e1.is_err));
          check("d1_val", e1.is_err ? 32'(err_code1) : 32'(cmd1), e1.val);
          check("d1_lat", cyc - rdy1, e1.lat);
        end
      end
      if (rsp_done0) begin
        ndone++;
        check("rsp_done_lat", cyc - txd0, 1);
      end
      if (d0.u_uart.rdy) rdy0 = cyc;
      if (d1.u_uart.rdy) rdy1 = cyc;
      if (d0.u_uart.tx_done) txd0 = cyc;
      prev0 = cmd_rdy0;
      prev1 = cmd_rdy1;
    end
  end
  initial begin
    forever begin
      @(negedge tx0);
      if (rst_n && cyc > 5) begin
        #240;
        for (int i = 0; i < 8; i++) begin
          b[i] = tx0;
          #160;
        end
        if (txq.size() == 0) check("tx_unexpected_byte", 32'(txq.size()), 1);
        else check("tx_byte", 32'(b), 32'(txq.pop_front()));
      end
    end
  end
  initial begin
    repeat (5) @(negedge clk);
    check("rst_cmd", 32'(cmd0), 0);
    check("rst_cmd_rdy", 32'(cmd_rdy0), 0);
    check("rst_frm_err", 32'(frm_err0), 0);
    check("rst_err_code", 32'(err_code0), ERR_NONE);
    check("rst_rsp_busy", 32'(rsp_busy0), 0);
    check("rst_rsp_done", 32'(rsp_done0), 0);
    check("rst_tx_idle", 32'(tx0), 1);
    rst_n = 1;
    repeat (5) @(negedge clk);
    q0.push_back('{1'b0, 32'hA51234, 1});
    send_frm(0, 3, 32'hA51234);
    check("norm_cmd", 32'(cmd0), 32'hA51234);
    check("norm_rdy", 32'(cmd_rdy0), 1);
    clr0 = 1;
    @(negedge clk);
    clr0 = 0;
    check("clr_rdy", 32'(cmd_rdy0), 0);
    check("clr_cmd_kept", 32'(cmd0), 32'hA51234);
    q0.push_back('{1'b1, 32'(ERR_TIMEOUT), 2000});
    send_frm(0, 2, 32'h1122);
    repeat (2100) @(negedge clk);
    check("to_no_rdy", 32'(cmd_rdy0), 0);
    check("to_code", 32'(err_code0), ERR_TIMEOUT);
    q0.push_back('{1'b0, 32'h010203, 1});
    send_frm(0, 3, 32'h010203);
    check("after_to_cmd", 32'(cmd0), 32'h010203);
    clr0 = 1;
    @(negedge clk);
    clr0 = 0;
    check("clr_err_none", 32'(err_code0), ERR_NONE);
    q0.push_back('{1'b0, 32'h0A0B0C, 1});
    send_frm(0, 3, 32'h0A0B0C);
    q0.push_back('{1'b1, 32'(ERR_OVERRUN), 1});
    send_frm(0, 3, 32'h0D0E0F);
    check("ovr_cmd_kept", 32'(cmd0), 32'h0A0B0C);
    check("ovr_rdy", 32'(cmd_rdy0), 1);
    check("ovr_code", 32'(err_code0), ERR_OVERRUN);
    txq.push_back(8'hC3);
    txq.push_back(8'h5A);
    send0 = 1;
    @(negedge clk);
    send0 = 0;
    check("rsp_busy_start", 32'(rsp_busy0), 1);
    repeat (100) @(negedge clk);
    check("rsp_busy_mid1", 32'(rsp_busy0), 1);
    rsp_data0 = 16'hFFFF;
    send0 = 1;
    @(negedge clk);
    send0 = 0;
    repeat (150) @(negedge clk);
    check("rsp_busy_mid2", 32'(rsp_busy0), 1);
    for (int i = 0; i < 1000 && ndone == 0; i++) @(negedge clk);
    check("rsp_done_seen", 32'(ndone), 1);
    check("rsp_busy_end", 32'(rsp_busy0), 0);
    repeat (400) @(negedge clk);
    check("rsp_done_once", 32'(ndone), 1);
    check("rsp_bytes_all", 32'(txq.size()), 0);
    send_byte(0, 8'h44);
    send_byte(0, 8'h55);
    rst_n = 0;
    repeat (2) @(negedge clk);
    check("mid_rst_cmd", 32'(cmd0), 0);
    check("mid_rst_rdy", 32'(cmd_rdy0), 0);
    check("mid_rst_code", 32'(err_code0), ERR_NONE);
    check("mid_rst_frm_err", 32'(frm_err0), 0);
    check("mid_rst_tx", 32'(tx0), 1);
    rst_n = 1;
    repeat (3) @(negedge clk);
    q0.push_back('{1'b0, 32'h778899, 1});
    send_frm(0, 3, 32'h778899);
    check("post_rst_cmd", 32'(cmd0), 32'h778899);
    q1.push_back('{1'b0, 32'h1020, 1});
    send_frm(1, 3, 32'h1020D0);
    check("ck_cmd", 32'(cmd1), 32'h1020);
    check("ck_rdy", 32'(cmd_rdy1), 1);
    clr1 = 1;
    @(negedge clk);
    clr1 = 0;
    q1.push_back('{1'b1, 32'(ERR_CHKSUM), 1});
    send_frm(1, 3, 32'h1020D1);
    check("ck_bad_rdy", 32'(cmd_rdy1), 0);
    check("ck_bad_code", 32'(err_code1), ERR_CHKSUM);
    check("ck_bad_cmd_kept", 32'(cmd1), 32'h1020);
    repeat (20) @(negedge clk);
    check("d0_events_all", 32'(q0.size()), 0);
    check("d1_events_all", 32'(q1.size()), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
